riscv_decode: RTL and testbench

RISCV_DECODE -- requirements
Module: riscv_decode

---
 rtl/riscv_defs.sv | 61 ++++++
 rtl/riscv_decode_if.sv | 40 ++++
 rtl/riscv_regfile.sv | 37 +++
 rtl/riscv_decode.sv | 185 ++++++++++++++++++
 tb/tb_riscv_decode.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_defs.sv
// Shared RV32I/M decode definitions: instruction-vector bit positions, major opcodes
// and the decoded slot payload layout.
package riscv_defs;

  localparam int XLEN   = 32;
  localparam int INST_W = 58;

  typedef enum int unsigned {
    ENUM_INST_LUI, ENUM_INST_AUIPC, ENUM_INST_JAL, ENUM_INST_JALR,
    ENUM_INST_BEQ, ENUM_INST_BNE, ENUM_INST_BLT, ENUM_INST_BGE, ENUM_INST_BLTU, ENUM_INST_BGEU,
    ENUM_INST_LB, ENUM_INST_LH, ENUM_INST_LW, ENUM_INST_LBU, ENUM_INST_LHU,
    ENUM_INST_SB, ENUM_INST_SH, ENUM_INST_SW,
    ENUM_INST_ADDI, ENUM_INST_SLTI, ENUM_INST_SLTIU, ENUM_INST_XORI, ENUM_INST_ORI,
    ENUM_INST_ANDI, ENUM_INST_SLLI, ENUM_INST_SRLI, ENUM_INST_SRAI,
    ENUM_INST_ADD, ENUM_INST_SUB, ENUM_INST_SLL, ENUM_INST_SLT, ENUM_INST_SLTU,
    ENUM_INST_XOR, ENUM_INST_SRL, ENUM_INST_SRA, ENUM_INST_OR, ENUM_INST_AND,
    ENUM_INST_FENCE, ENUM_INST_FENCE_I,
    ENUM_INST_ECALL, ENUM_INST_EBREAK, ENUM_INST_MRET, ENUM_INST_SRET, ENUM_INST_WFI,
    ENUM_INST_CSRRW, ENUM_INST_CSRRS, ENUM_INST_CSRRC,
    ENUM_INST_CSRRWI, ENUM_INST_CSRRSI, ENUM_INST_CSRRCI,
    ENUM_INST_MUL, ENUM_INST_MULH, ENUM_INST_MULHSU, ENUM_INST_MULHU,
    ENUM_INST_DIV, ENUM_INST_DIVU, ENUM_INST_REM, ENUM_INST_REMU
  } inst_id_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
  localparam logic [31:0] INSTR_SRET   = 32'h1020_0073;
  localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

  typedef struct packed {
    logic [INST_W-1:0] instr;
    logic [XLEN-1:0]   opcode;
    logic [XLEN-1:0]   pc;
    logic [4:0]        rd;
    logic [4:0]        ra;
    logic [4:0]        rb;
    logic              illegal;
  } slot_t;

  function automatic logic [INST_W-1:0] inst_bit(input inst_id_e id);
    return {{(INST_W-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/riscv_decode_if.sv
// Fetch slot, execute control, writeback port and decoded opcode slot of the decode stage.
interface riscv_decode_if;

  logic                            fetch_valid_i;
  logic [31:0]                     fetch_instr_i;
  logic [31:0]                     fetch_pc_i;
  logic                            fetch_accept_o;
  logic                            branch_request_i;
  logic                            stall_i;
  logic [4:0]                      writeback_idx_i;
  logic                            writeback_squash_i;
  logic [31:0]                     writeback_value_i;
  logic                            opcode_valid_o;
  logic [riscv_defs::INST_W-1:0]   opcode_instr_o;
  logic [31:0]                     opcode_opcode_o;
  logic [31:0]                     opcode_pc_o;
  logic [4:0]                      opcode_rd_idx_o;
  logic [4:0]                      opcode_ra_idx_o;
  logic [4:0]                      opcode_rb_idx_o;
  logic [31:0]                     opcode_ra_operand_o;
  logic [31:0]                     opcode_rb_operand_o;
  logic                            illegal_o;

  modport slave (
    input  fetch_valid_i, fetch_instr_i, fetch_pc_i, branch_request_i, stall_i,
           writeback_idx_i, writeback_squash_i, writeback_value_i,
    output fetch_accept_o, opcode_valid_o, opcode_instr_o, opcode_opcode_o, opcode_pc_o,
           opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o,
           opcode_ra_operand_o, opcode_rb_operand_o, illegal_o
  );

  modport master (
    output fetch_valid_i, fetch_instr_i, fetch_pc_i, branch_request_i, stall_i,
           writeback_idx_i, writeback_squash_i, writeback_value_i,
    input  fetch_accept_o, opcode_valid_o, opcode_instr_o, opcode_opcode_o, opcode_pc_o,
           opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o,
           opcode_ra_operand_o, opcode_rb_operand_o, illegal_o
  );

endinterface

// File: rtl/riscv_regfile.sv
// 32x32 integer register file, two read ports with same-cycle write bypass; x0 reads zero.
module riscv_regfile
  import riscv_defs::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en,
  input  logic [4:0]      wr_idx,
  input  logic [XLEN-1:0] wr_value,
  input  logic [4:0]      ra_idx,
  input  logic [4:0]      rb_idx,
  output logic [XLEN-1:0] ra_value,
  output logic [XLEN-1:0] rb_value
);

  logic [XLEN-1:0] regs [32];
  logic            wr_live;

  assign wr_live = wr_en && (wr_idx != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_idx] <= wr_value;
    end
  end

  // Reads see the value being written this cycle, so dependents need no bubble.
  always_comb begin
    ra_value = '0;
    rb_value = '0;
    if (ra_idx != '0) ra_value = (wr_live && wr_idx == ra_idx) ? wr_value : regs[ra_idx];
    if (rb_idx != '0) rb_value = (wr_live && wr_idx == rb_idx) ? wr_value : regs[rb_idx];
  end

endmodule

// File: rtl/riscv_decode.sv
// RV32I/M decode stage: single registered opcode slot with one-hot instruction vector
// and register operands captured from the register file.
module riscv_decode
  import riscv_defs::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  riscv_decode_if.slave  bus
);

  logic              fetch_accept;
  logic              load;
  logic              valid_q;
  slot_t             slot_q;
  logic [XLEN-1:0]   ra_op_q;
  logic [XLEN-1:0]   rb_op_q;
  logic [INST_W-1:0] dec;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [4:0]        ra_sel;
  logic [4:0]        rb_sel;
  logic [XLEN-1:0]   ra_value;
  logic [XLEN-1:0]   rb_value;

  assign fetch_accept = !bus.stall_i && !bus.branch_request_i;
  assign load         = bus.fetch_valid_i && fetch_accept;
  assign opc          = bus.fetch_instr_i[6:0];
  assign f3           = bus.fetch_instr_i[14:12];
  assign f7           = bus.fetch_instr_i[31:25];

  always_comb begin
    dec = '0;
    case (opc)
      OPC_LUI:   dec = inst_bit(ENUM_INST_LUI);
      OPC_AUIPC: dec = inst_bit(ENUM_INST_AUIPC);
      OPC_JAL:   dec = inst_bit(ENUM_INST_JAL);
      OPC_JALR:  if (f3 == 3'd0) dec = inst_bit(ENUM_INST_JALR);
      OPC_BRANCH:
        case (f3)
          3'd0: dec = inst_bit(ENUM_INST_BEQ);
          3'd1: dec = inst_bit(ENUM_INST_BNE);
          3'd4: dec = inst_bit(ENUM_INST_BLT);
          3'd5: dec = inst_bit(ENUM_INST_BGE);
          3'd6: dec = inst_bit(ENUM_INST_BLTU);
          3'd7: dec = inst_bit(ENUM_INST_BGEU);
          default: ;
        endcase
      OPC_LOAD:
        case (f3)
          3'd0: dec = inst_bit(ENUM_INST_LB);
          3'd1: dec = inst_bit(ENUM_INST_LH);
          3'd2: dec = inst_bit(ENUM_INST_LW);
          3'd4: dec = inst_bit(ENUM_INST_LBU);
          3'd5: dec = inst_bit(ENUM_INST_LHU);
          default: ;
        endcase
      OPC_STORE:
        case (f3)
          3'd0: dec = inst_bit(ENUM_INST_SB);
          3'd1: dec = inst_bit(ENUM_INST_SH);
          3'd2: dec = inst_bit(ENUM_INST_SW);
          default: ;
        endcase
      OPC_OPIMM:
        case (f3)
          3'd0: dec = inst_bit(ENUM_INST_ADDI);
          3'd2: dec = inst_bit(ENUM_INST_SLTI);
          3'd3: dec = inst_bit(ENUM_INST_SLTIU);
          3'd4: dec = inst_bit(ENUM_INST_XORI);
          3'd6: dec = inst_bit(ENUM_INST_ORI);
          3'd7: dec = inst_bit(ENUM_INST_ANDI);
          3'd1: if (f7 == F7_BASE) dec = inst_bit(ENUM_INST_SLLI);
          3'd5: begin
            if (f7 == F7_BASE)     dec = inst_bit(ENUM_INST_SRLI);
            else if (f7 == F7_ALT) dec = inst_bit(ENUM_INST_SRAI);
          end
          default: ;
        endcase
      OPC_OP:
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0: dec = inst_bit(ENUM_INST_ADD);
            3'd1: dec = inst_bit(ENUM_INST_SLL);
            3'd2: dec = inst_bit(ENUM_INST_SLT);
            3'd3: dec = inst_bit(ENUM_INST_SLTU);
            3'd4: dec = inst_bit(ENUM_INST_XOR);
            3'd5: dec = inst_bit(ENUM_INST_SRL);
            3'd6: dec = inst_bit(ENUM_INST_OR);
            default: dec = inst_bit(ENUM_INST_AND);
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'd0)      dec = inst_bit(ENUM_INST_SUB);
          else if (f3 == 3'd5) dec = inst_bit(ENUM_INST_SRA);
        end else if (f7 == F7_MULDIV) begin
          case (f3)
            3'd0: dec = inst_bit(ENUM_INST_MUL);
            3'd1: dec = inst_bit(ENUM_INST_MULH);
            3'd2: dec = inst_bit(ENUM_INST_MULHSU);
            3'd3: dec = inst_bit(ENUM_INST_MULHU);
            3'd4: dec = inst_bit(ENUM_INST_DIV);
            3'd5: dec = inst_bit(ENUM_INST_DIVU);
            3'd6: dec = inst_bit(ENUM_INST_REM);
            default: dec = inst_bit(ENUM_INST_REMU);
          endcase
        end
      OPC_MISC_MEM:
        if (f3 == 3'd0)      dec = inst_bit(ENUM_INST_FENCE);
        else if (f3 == 3'd1) dec = inst_bit(ENUM_INST_FENCE_I);
      OPC_SYSTEM:
        case (f3)
          3'd0:
            case (bus.fetch_instr_i)
              INSTR_ECALL:  dec = inst_bit(ENUM_INST_ECALL);
              INSTR_EBREAK: dec = inst_bit(ENUM_INST_EBREAK);
              INSTR_MRET:   dec = inst_bit(ENUM_INST_MRET);
              INSTR_SRET:   dec = inst_bit(ENUM_INST_SRET);
              INSTR_WFI:    dec = inst_bit(ENUM_INST_WFI);
              default: ;
            endcase
          3'd1: dec = inst_bit(ENUM_INST_CSRRW);
          3'd2: dec = inst_bit(ENUM_INST_CSRRS);
          3'd3: dec = inst_bit(ENUM_INST_CSRRC);
          3'd5: dec = inst_bit(ENUM_INST_CSRRWI);
          3'd6: dec = inst_bit(ENUM_INST_CSRRSI);
          3'd7: dec = inst_bit(ENUM_INST_CSRRCI);
          default: ;
        endcase
      default: ;
    endcase
  end

  // Operands are re-read every cycle: from the incoming instruction on a load,
  // otherwise from the held slot so stalled consumers see late writebacks.
  assign ra_sel = load ? bus.fetch_instr_i[19:15] : slot_q.ra;
  assign rb_sel = load ? bus.fetch_instr_i[24:20] : slot_q.rb;

  riscv_regfile u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en    (!bus.writeback_squash_i),
    .wr_idx   (bus.writeback_idx_i),
    .wr_value (bus.writeback_value_i),
    .ra_idx   (ra_sel),
    .rb_idx   (rb_sel),
    .ra_value (ra_value),
    .rb_value (rb_value)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
      ra_op_q <= '0;
      rb_op_q <= '0;
    end else begin
      if (bus.branch_request_i) valid_q <= 1'b0;
      else if (!bus.stall_i)    valid_q <= bus.fetch_valid_i;
      if (load) begin
        slot_q.instr   <= dec;
        slot_q.opcode  <= bus.fetch_instr_i;
        slot_q.pc      <= bus.fetch_pc_i;
        slot_q.rd      <= bus.fetch_instr_i[11:7];
        slot_q.ra      <= bus.fetch_instr_i[19:15];
        slot_q.rb      <= bus.fetch_instr_i[24:20];
        slot_q.illegal <= (dec == '0);
      end
      ra_op_q <= ra_value;
      rb_op_q <= rb_value;
    end
  end

  assign bus.fetch_accept_o      = fetch_accept;
  assign bus.opcode_valid_o      = valid_q;
  assign bus.opcode_instr_o      = slot_q.instr;
  assign bus.opcode_opcode_o     = slot_q.opcode;
  assign bus.opcode_pc_o         = slot_q.pc;
  assign bus.opcode_rd_idx_o     = slot_q.rd;
  assign bus.opcode_ra_idx_o     = slot_q.ra;
  assign bus.opcode_rb_idx_o     = slot_q.rb;
  assign bus.opcode_ra_operand_o = ra_op_q;
  assign bus.opcode_rb_operand_o = rb_op_q;
  assign bus.illegal_o           = valid_q && slot_q.illegal;

endmodule

// File: tb/tb_riscv_decode.sv
// Scoreboard bench for riscv_decode: a mask/match instruction table and an architectural
// register array predict each cycle's slot; a negedge monitor compares.
module tb_riscv_decode;
  import riscv_defs::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_decode_if bus ();

  riscv_decode dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          id;
  } pat_t;

  typedef struct {
    int unsigned cyc;
    logic        valid;
    logic        illegal;
    logic        full;
    logic [57:0] vec;
    logic [31:0] opc;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ra_op;
    logic [31:0] rb_op;
  } exp_t;

  pat_t        table_q[$];
  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [31:0] m_regs [32];
  exp_t        m;
  logic        m_illegal_flag;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
  endfunction

  task automatic add(input logic [31:0] mask, input logic [31:0] match, input inst_id_e id);
    pat_t p;
    p.mask = mask; p.match = match; p.id = int'(id);
    table_q.push_back(p);
  endtask

  task automatic build_table();
    localparam logic [31:0] R = 32'hFE00_707F, I = 32'h0000_707F, U = 32'h0000_007F, E = 32'hFFFF_FFFF;
    add(U, 32'h37, ENUM_INST_LUI);      add(U, 32'h17, ENUM_INST_AUIPC);
    add(U, 32'h6F, ENUM_INST_JAL);      add(I, 32'h67, ENUM_INST_JALR);
    add(I, 32'h0063, ENUM_INST_BEQ);    add(I, 32'h1063, ENUM_INST_BNE);
    add(I, 32'h4063, ENUM_INST_BLT);    add(I, 32'h5063, ENUM_INST_BGE);
    add(I, 32'h6063, ENUM_INST_BLTU);   add(I, 32'h7063, ENUM_INST_BGEU);
    add(I, 32'h0003, ENUM_INST_LB);     add(I, 32'h1003, ENUM_INST_LH);
    add(I, 32'h2003, ENUM_INST_LW);     add(I, 32'h4003, ENUM_INST_LBU);
    add(I, 32'h5003, ENUM_INST_LHU);    add(I, 32'h0023, ENUM_INST_SB);
    add(I, 32'h1023, ENUM_INST_SH);     add(I, 32'h2023, ENUM_INST_SW);
    add(I, 32'h0013, ENUM_INST_ADDI);   add(I, 32'h2013, ENUM_INST_SLTI);
    add(I, 32'h3013, ENUM_INST_SLTIU);  add(I, 32'h4013, ENUM_INST_XORI);
    add(I, 32'h6013, ENUM_INST_ORI);    add(I, 32'h7013, ENUM_INST_ANDI);
    add(R, 32'h1013, ENUM_INST_SLLI);   add(R, 32'h5013, ENUM_INST_SRLI);
    add(R, 32'h4000_5013, ENUM_INST_SRAI);
    add(R, 32'h0033, ENUM_INST_ADD);    add(R, 32'h4000_0033, ENUM_INST_SUB);
    add(R, 32'h1033, ENUM_INST_SLL);    add(R, 32'h2033, ENUM_INST_SLT);
    add(R, 32'h3033, ENUM_INST_SLTU);   add(R, 32'h4033, ENUM_INST_XOR);
    add(R, 32'h5033, ENUM_INST_SRL);    add(R, 32'h4000_5033, ENUM_INST_SRA);
    add(R, 32'h6033, ENUM_INST_OR);     add(R, 32'h7033, ENUM_INST_AND);
    add(I, 32'h000F, ENUM_INST_FENCE);  add(I, 32'h100F, ENUM_INST_FENCE_I);
    add(E, 32'h0000_0073, ENUM_INST_ECALL); add(E, 32'h0010_0073, ENUM_INST_EBREAK);
    add(E, 32'h3020_0073, ENUM_INST_MRET);  add(E, 32'h1020_0073, ENUM_INST_SRET);
    add(E, 32'h1050_0073, ENUM_INST_WFI);
    add(I, 32'h1073, ENUM_INST_CSRRW);  add(I, 32'h2073, ENUM_INST_CSRRS);
    add(I, 32'h3073, ENUM_INST_CSRRC);  add(I, 32'h5073, ENUM_INST_CSRRWI);
    add(I, 32'h6073, ENUM_INST_CSRRSI); add(I, 32'h7073, ENUM_INST_CSRRCI);
    add(R, 32'h0200_0033, ENUM_INST_MUL);    add(R, 32'h0200_1033, ENUM_INST_MULH);
    add(R, 32'h0200_2033, ENUM_INST_MULHSU); add(R, 32'h0200_3033, ENUM_INST_MULHU);
    add(R, 32'h0200_4033, ENUM_INST_DIV);    add(R, 32'h0200_5033, ENUM_INST_DIVU);
    add(R, 32'h0200_6033, ENUM_INST_REM);    add(R, 32'h0200_7033, ENUM_INST_REMU);
  endtask

  function automatic int ref_decode(input logic [31:0] ins);
    foreach (table_q[k]) if ((ins & table_q[k].mask) == table_q[k].match) return table_q[k].id;
    return -1;
  endfunction

  function automatic logic [31:0] legal_instr();
    pat_t p;
    p = table_q[$urandom_range(0, table_q.size() - 1)];
    return ($urandom() & ~p.mask) | p.match;
  endfunction

  // One clock of stimulus; the model advances to the state expected after the next edge.
  task automatic step(input logic r, input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic br, input logic st, input logic [4:0] wi, input logic sq,
                      input logic [31:0] wv);
    int id;
    exp_t e;
    rst = r;
    bus.fetch_valid_i = fv;       bus.fetch_instr_i = ins;       bus.fetch_pc_i = pc;
    bus.branch_request_i = br;    bus.stall_i = st;
    bus.writeback_idx_i = wi;     bus.writeback_squash_i = sq;   bus.writeback_value_i = wv;
    #1;
    chk("fetch_accept", 64'(bus.fetch_accept_o), 64'(!st && !br));
    if (r) begin
      for (int k = 0; k < 32; k++) m_regs[k] = '0;
      m = '{default: '0};
      m_illegal_flag = 1'b0;
    end else begin
      if (!sq && wi != 0) m_regs[wi] = wv;
      if (br) m.valid = 1'b0;
      else if (!st) begin
        m.valid = fv;
        if (fv) begin
          id = ref_decode(ins);
          m.vec = (id < 0) ? 58'd0 : (58'd1 << id);
          m_illegal_flag = (id < 0);
          m.opc = ins; m.pc = pc;
          m.rd = ins[11:7]; m.ra = ins[19:15]; m.rb = ins[24:20];
        end
      end
      m.ra_op = m_regs[m.ra];
      m.rb_op = m_regs[m.rb];
    end
    e = m;
    e.cyc = cyc + 1;
    e.illegal = m.valid && m_illegal_flag;
    e.full = m.valid || r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk("slot_cycle", 64'(e.cyc), 64'(cyc));
      chk("valid", 64'(bus.opcode_valid_o), 64'(e.valid));
      chk("illegal", 64'(bus.illegal_o), 64'(e.illegal));
      if (e.full) begin
        chk("instr_vec", 64'(bus.opcode_instr_o), 64'(e.vec));
        chk("opcode", 64'(bus.opcode_opcode_o), 64'(e.opc));
        chk("pc", 64'(bus.opcode_pc_o), 64'(e.pc));
        chk("rd_idx", 64'(bus.opcode_rd_idx_o), 64'(e.rd));
        chk("ra_idx", 64'(bus.opcode_ra_idx_o), 64'(e.ra));
        chk("rb_idx", 64'(bus.opcode_rb_idx_o), 64'(e.rb));
        chk("ra_operand", 64'(bus.opcode_ra_operand_o), 64'(e.ra_op));
        chk("rb_operand", 64'(bus.opcode_rb_operand_o), 64'(e.rb_op));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic r, fv, br, st, sq;
    logic [31:0] ins, wv;
    logic [4:0] wi;
    build_table();
    for (int k = 0; k < 32; k++) m_regs[k] = '0;
    m = '{default: '0};
    m_illegal_flag = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 32'h0050_0093, 32'h44, 0, 0, 5'd3, 0, 32'h1234);
    step(0, 1, 32'h0050_0093, 32'h100, 0, 0, 0, 1, 0);
    chk("addi_bit_only", 64'(bus.opcode_instr_o), 64'(58'd1 << int'(ENUM_INST_ADDI)));
    step(0, 0, 0, 0, 0, 0, 5'd1, 0, 32'd5);
    step(0, 1, 32'h0020_81B3, 32'h104, 0, 0, 5'd2, 0, 32'd7);
    chk("bypass_rb_is_7", 64'(bus.opcode_rb_operand_o), 64'd7);
    step(0, 1, 32'h0000_0013, 32'h108, 0, 1, 0, 1, 0);
    step(0, 1, 32'h0000_0013, 32'h108, 0, 1, 5'd1, 0, 32'd9);
    step(0, 1, 32'h0000_0013, 32'h108, 0, 1, 0, 1, 0);
    step(0, 1, 32'h0000_0013, 32'h10C, 1, 1, 0, 1, 0);
    step(0, 1, 32'hFFFF_FFFF, 32'h110, 0, 0, 5'd0, 0, 32'hDEAD);
    step(0, 1, 32'h0000_02B3, 32'h114, 0, 0, 0, 1, 0);

    for (int i = 0; i < 300; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      fv  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 3) == 0);
      ins = ($urandom_range(0, 9) < 8) ? legal_instr() : $urandom();
      wi  = $urandom_range(0, 1) ? m.ra : 5'($urandom_range(0, 31));
      sq  = ($urandom_range(0, 2) == 0);
      wv  = $urandom();
      step(r, fv, ins, $urandom(), br, st, wi, sq, wv);
    end

    step(0, 1, 32'h0020_81B3, 32'h200, 0, 0, 5'd1, 0, 32'h55);
    step(1, 1, 32'h0020_81B3, 32'h204, 0, 0, 5'd2, 0, 32'h66);
    step(0, 1, 32'h0020_81B3, 32'h208, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
